fetch_stage: RTL and testbench

//  Fetch stage: owns the fetch PC, runs the instruction-memory request/response handshake, and holds one fetched instruction.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, runs a single-outstanding imem handshake,
// holds one fetched instruction and feeds the F/D pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic        stall_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        fetch_valid,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d
);

    // Handshake: a request is issued while imem_req=1 and is taken on the
    // cycle imem_gnt=1; its single response arrives later with imem_rvalid=1.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        drop, drop_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic        accept;

    assign accept      = (state == S_HOLD) & ~stall_d & ~redirect;
    assign fetch_valid = (state == S_HOLD);
    assign instr_f     = fetch_valid ? instr_q : NOP;
    assign imem_req    = (state == S_REQ) & ~rst;
    assign imem_addr   = pc_q;
    assign pc_f        = pc_q;

    always_comb begin
        state_n = state;
        drop_n  = drop;
        pc_n    = pc_q;
        instr_n = instr_q;
        unique case (state)
            S_REQ: begin
                // A grant taken in the same cycle as a redirect is for the old PC.
                if (imem_gnt) begin
                    state_n = S_WAIT;
                    drop_n  = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_n = 1'b0;
                    if (drop || redirect) begin
                        state_n = S_REQ;
                    end else begin
                        state_n = S_HOLD;
                        instr_n = imem_rdata;
                    end
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || accept) state_n = S_REQ;
            end
            default: begin
                state_n = S_REQ;
                drop_n  = 1'b0;
            end
        endcase
        if (redirect || accept) pc_n = pc_next;
        if (redirect) instr_n = NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_REQ;
            drop    <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state   <= state_n;
            drop    <= drop_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
        end
    end

    // F/D register: a redirect squashes it even while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_d    <= 32'h0;
            instr_d <= NOP;
            valid_d <= 1'b0;
        end else if (redirect) begin
            instr_d <= NOP;
            valid_d <= 1'b0;
        end else if (stall_d) begin
            pc_d    <= pc_d;
            instr_d <= instr_d;
            valid_d <= valid_d;
        end else if (accept) begin
            pc_d    <= pc_q;
            instr_d <= instr_f;
            valid_d <= 1'b1;
        end else begin
            instr_d <= NOP;
            valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written
// stall and mid-transaction reset sequences, with a decode-side scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic        redirect;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        fetch_valid;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .redirect(redirect),
        .stall_d(stall_d), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_f(pc_f), .instr_f(instr_f), .fetch_valid(fetch_valid),
        .pc_d(pc_d), .instr_d(instr_d), .valid_d(valid_d)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst;
        logic [31:0] pn;
        logic        redir;
        logic        stall;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_if;
        logic        e_vd;
        logic [31:0] e_pcd;
        logic [31:0] e_id;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pn, input logic redir, input logic stall,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr, input logic e_fv,
                                input logic [31:0] e_if, input logic e_vd,
                                input logic [31:0] e_pcd, input logic [31:0] e_id);
        vec_t v;
        v.rst = 1'b0; v.pn = pn; v.redir = redir; v.stall = stall; v.gnt = gnt;
        v.rv = rv; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
        v.e_if = e_if; v.e_vd = e_vd; v.e_pcd = e_pcd; v.e_id = e_id;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic check_outputs(input int idx, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_fv, input logic [31:0] e_if, input logic e_vd,
                                 input logic [31:0] e_pcd, input logic [31:0] e_id);
        chk("imem_req", idx, {31'b0, imem_req}, {31'b0, e_req});
        chk("imem_addr", idx, imem_addr, e_addr);
        chk("pc_f", idx, pc_f, e_addr);
        chk("fetch_valid", idx, {31'b0, fetch_valid}, {31'b0, e_fv});
        chk("instr_f", idx, instr_f, e_if);
        chk("valid_d", idx, {31'b0, valid_d}, {31'b0, e_vd});
        chk("pc_d", idx, pc_d, e_pcd);
        chk("instr_d", idx, instr_d, e_id);
    endtask

    // Called right after a falling edge: drive, settle, check, consume, advance.
    task automatic apply(input int idx, input vec_t v);
        rst         = v.rst;
        pc_next     = v.pn;
        redirect    = v.redir;
        stall_d     = v.stall;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        #1;
        check_outputs(idx, v.e_req, v.e_addr, v.e_fv, v.e_if, v.e_vd, v.e_pcd, v.e_id);
        // Decode takes the F/D entry on this edge when valid, not stalled, not flushed.
        if (valid_d && !stall_d && !redirect) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL decode_consume step %0d: got %h expected none", idx, instr_d);
            end else begin
                chk("decode_consume", idx, instr_d, exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    vec_t tbl[26];

    initial begin
        rst = 1'b1; pc_next = '0; redirect = 1'b0; stall_d = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        exp_q = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008, 32'hA000_0300, 32'hA000_0304};

        //            pn           rd st gn rv rdata          req addr         fv instr_f       vd pc_d         instr_d
        // sequential fetch 0,4,8 with 1-cycle memory
        tbl[0]  = mk(32'h004,     0, 0, 1, 0, 32'h0,         1, 32'h000,      0, NOP,          0, 32'h000,     NOP);
        tbl[1]  = mk(32'h004,     0, 0, 0, 1, 32'hA000_0000, 0, 32'h000,      0, NOP,          0, 32'h000,     NOP);
        tbl[2]  = mk(32'h004,     0, 0, 0, 0, 32'h0,         0, 32'h000,      1, 32'hA000_0000,0, 32'h000,     NOP);
        tbl[3]  = mk(32'h008,     0, 0, 1, 0, 32'h0,         1, 32'h004,      0, NOP,          1, 32'h000,     32'hA000_0000);
        tbl[4]  = mk(32'h008,     0, 0, 0, 1, 32'hA000_0004, 0, 32'h004,      0, NOP,          0, 32'h000,     NOP);
        tbl[5]  = mk(32'h008,     0, 0, 0, 0, 32'h0,         0, 32'h004,      1, 32'hA000_0004,0, 32'h000,     NOP);
        tbl[6]  = mk(32'h00C,     0, 0, 1, 0, 32'h0,         1, 32'h008,      0, NOP,          1, 32'h004,     32'hA000_0004);
        tbl[7]  = mk(32'h00C,     0, 0, 0, 1, 32'hA000_0008, 0, 32'h008,      0, NOP,          0, 32'h004,     NOP);
        tbl[8]  = mk(32'h00C,     0, 0, 0, 0, 32'h0,         0, 32'h008,      1, 32'hA000_0008,0, 32'h004,     NOP);
        tbl[9]  = mk(32'h010,     0, 0, 0, 0, 32'h0,         1, 32'h00C,      0, NOP,          1, 32'h008,     32'hA000_0008);
        // redirect in WAIT, response two cycles later is discarded
        tbl[10] = mk(32'h010,     0, 0, 1, 0, 32'h0,         1, 32'h00C,      0, NOP,          0, 32'h008,     NOP);
        tbl[11] = mk(32'h100,     1, 0, 0, 0, 32'h0,         0, 32'h00C,      0, NOP,          0, 32'h008,     NOP);
        tbl[12] = mk(32'h104,     0, 0, 0, 0, 32'h0,         0, 32'h100,      0, NOP,          0, 32'h008,     NOP);
        tbl[13] = mk(32'h104,     0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h100,      0, NOP,          0, 32'h008,     NOP);
        tbl[14] = mk(32'h104,     0, 0, 1, 0, 32'h0,         1, 32'h100,      0, NOP,          0, 32'h008,     NOP);
        tbl[15] = mk(32'h104,     0, 0, 0, 1, 32'hA000_0100, 0, 32'h100,      0, NOP,          0, 32'h008,     NOP);
        tbl[16] = mk(32'h104,     0, 0, 0, 0, 32'h0,         0, 32'h100,      1, 32'hA000_0100,0, 32'h008,     NOP);
        // redirect coincident with grant: stale response dropped
        tbl[17] = mk(32'h200,     1, 0, 1, 0, 32'h0,         1, 32'h104,      0, NOP,          1, 32'h100,     32'hA000_0100);
        tbl[18] = mk(32'h204,     0, 0, 0, 1, 32'hBAD0_BAD0, 0, 32'h200,      0, NOP,          0, 32'h100,     NOP);
        tbl[19] = mk(32'h204,     0, 0, 1, 0, 32'h0,         1, 32'h200,      0, NOP,          0, 32'h100,     NOP);
        tbl[20] = mk(32'h204,     0, 0, 0, 1, 32'hA000_0200, 0, 32'h200,      0, NOP,          0, 32'h100,     NOP);
        tbl[21] = mk(32'h204,     0, 0, 0, 0, 32'h0,         0, 32'h200,      1, 32'hA000_0200,0, 32'h100,     NOP);
        // redirect plus stall in HOLD squashes a held-valid F/D entry
        tbl[22] = mk(32'h208,     0, 1, 1, 0, 32'h0,         1, 32'h204,      0, NOP,          1, 32'h200,     32'hA000_0200);
        tbl[23] = mk(32'h208,     0, 1, 0, 1, 32'hA000_0204, 0, 32'h204,      0, NOP,          1, 32'h200,     32'hA000_0200);
        tbl[24] = mk(32'h300,     1, 1, 0, 0, 32'h0,         0, 32'h204,      1, 32'hA000_0204,1, 32'h200,     32'hA000_0200);
        tbl[25] = mk(32'h304,     0, 0, 0, 0, 32'h0,         1, 32'h300,      0, NOP,          0, 32'h200,     NOP);

        // reset state while rst is held
        #1;
        check_outputs(0, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 32'h0, NOP);
        @(negedge clk);

        for (int i = 0; i < 26; i++) apply(100 + i, tbl[i]);

        // stall held for 5 cycles in HOLD, then released
        apply(200, mk(32'h304, 0, 0, 1, 0, 32'h0,         1, 32'h300, 0, NOP,           0, 32'h200, NOP));
        apply(201, mk(32'h304, 0, 0, 0, 1, 32'hA000_0300, 0, 32'h300, 0, NOP,           0, 32'h200, NOP));
        apply(202, mk(32'h304, 0, 0, 0, 0, 32'h0,         0, 32'h300, 1, 32'hA000_0300, 0, 32'h200, NOP));
        apply(203, mk(32'h308, 0, 1, 1, 0, 32'h0,         1, 32'h304, 0, NOP,           1, 32'h300, 32'hA000_0300));
        apply(204, mk(32'h308, 0, 1, 0, 1, 32'hA000_0304, 0, 32'h304, 0, NOP,           1, 32'h300, 32'hA000_0300));
        for (int i = 0; i < 5; i++)
            apply(205 + i, mk(32'h308, 0, 1, 0, 0, 32'h0, 0, 32'h304, 1, 32'hA000_0304, 1, 32'h300, 32'hA000_0300));
        apply(210, mk(32'h308, 0, 0, 0, 0, 32'h0,         0, 32'h304, 1, 32'hA000_0304, 1, 32'h300, 32'hA000_0300));
        apply(211, mk(32'h30C, 0, 0, 1, 0, 32'h0,         1, 32'h308, 0, NOP,           1, 32'h304, 32'hA000_0304));

        // asynchronous reset asserted in WAIT, late response afterwards ignored
        imem_gnt = 1'b0; imem_rvalid = 1'b0; stall_d = 1'b0; redirect = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_outputs(300, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 32'h0, NOP);
        @(negedge clk);
        apply(301, mk(32'h004, 0, 0, 0, 1, 32'hBADB_AD00, 1, 32'h000, 0, NOP, 0, 32'h000, NOP));
        apply(302, mk(32'h004, 0, 0, 0, 0, 32'h0,         1, 32'h000, 0, NOP, 0, 32'h000, NOP));
        apply(303, mk(32'h004, 0, 0, 1, 0, 32'h0,         1, 32'h000, 0, NOP, 0, 32'h000, NOP));
        apply(304, mk(32'h004, 0, 0, 0, 1, 32'hA000_0000, 0, 32'h000, 0, NOP, 0, 32'h000, NOP));
        apply(305, mk(32'h004, 0, 1, 0, 0, 32'h0,         0, 32'h000, 1, 32'hA000_0000, 0, 32'h000, NOP));

        chk("exp_q_left", 400, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
